// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - op codes and signed range helpers for fxp_addsub_pipe
package fxp_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ACC = 2'd2;
  localparam logic [1:0] OP_NEG = 2'd3;

  // Largest signed value of the given width, right-aligned in 32 bits.
  function automatic logic [31:0] fxp_max(input int width);
    return 32'((64'sd1 <<< (width - 1)) - 64'sd1);
  endfunction

  function automatic logic [31:0] fxp_min(input int width);
    return 32'(-(64'sd1 <<< (width - 1)));
  endfunction

endpackage

// File: rtl/fxp_addsub_pipe_if.sv
// rtl/fxp_addsub_pipe_if.sv - operand/result handshake bundle for fxp_addsub_pipe
interface fxp_addsub_pipe_if #(
  parameter int DATA_W = 8
);

  logic              i_valid;
  logic              o_ready;
  logic [1:0]        i_op;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic              i_acc_clr;
  logic              i_clr_ovf;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_ovf;
  logic              o_ovf_sticky;

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_acc_clr, i_clr_ovf, i_ready,
    output o_ready, o_valid, o_data, o_ovf, o_ovf_sticky
  );

  modport master (
    output i_valid, i_op, i_a, i_b, i_acc_clr, i_clr_ovf, i_ready,
    input  o_ready, o_valid, o_data, o_ovf, o_ovf_sticky
  );

endinterface

// File: rtl/fxp_reduce.sv
// rtl/fxp_reduce.sv - narrows a DATA_W+1 exact sum to DATA_W by saturation or wrap
module fxp_reduce
  import fxp_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SATURATE = 1
) (
  input  logic [DATA_W:0]   exact,
  output logic [DATA_W-1:0] data,
  output logic              ovf
);

  localparam logic [31:0] MAX_W = fxp_max(DATA_W);
  localparam logic [31:0] MIN_W = fxp_min(DATA_W);

  always_comb begin
    ovf  = exact[DATA_W] ^ exact[DATA_W-1];
    data = exact[DATA_W-1:0];
    // The extra sign bit tells which rail was crossed.
    if (ovf && (SATURATE != 0)) begin
      data = exact[DATA_W] ? MIN_W[DATA_W-1:0] : MAX_W[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fxp_addsub_pipe.sv
// rtl/fxp_addsub_pipe.sv - two-stage signed fixed-point add/sub/acc/neg unit
module fxp_addsub_pipe
  import fxp_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SATURATE = 1
) (
  input logic               i_clk,
  input logic               i_reset_n,
  fxp_addsub_pipe_if.slave  bus
);

  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s2_load;
  logic                     s1_adv;
  logic                     ready;
  logic                     accept;
  logic [DATA_W:0]          s1_exact;
  logic [DATA_W:0]          exact_in;
  logic [DATA_W-1:0]        acc;
  logic [DATA_W-1:0]        acc_base;
  logic [DATA_W-1:0]        acc_next;
  logic                     acc_ovf_unused;
  logic [DATA_W-1:0]        s2_data;
  logic                     s2_ovf;
  logic [DATA_W-1:0]        data_q;
  logic                     ovf_q;
  logic                     sticky_q;
  logic signed [DATA_W:0]   sa;
  logic signed [DATA_W:0]   sb;
  logic signed [DATA_W:0]   sacc;

  assign s2_load = !s2_valid || bus.i_ready;
  assign s1_adv  = s1_valid && s2_load;
  assign ready   = !s1_valid || s2_load;
  assign accept  = bus.i_valid && ready;

  // A clear arriving with an ACC op wins, so the op sums against zero.
  always_comb begin
    acc_base = bus.i_acc_clr ? '0 : acc;
    sa       = {bus.i_a[DATA_W-1], bus.i_a};
    sb       = {bus.i_b[DATA_W-1], bus.i_b};
    sacc     = {acc_base[DATA_W-1], acc_base};
    case (bus.i_op)
      OP_ADD:  exact_in = sa + sb;
      OP_SUB:  exact_in = sa - sb;
      OP_ACC:  exact_in = sacc + sa;
      default: exact_in = '0 - sa;
    endcase
  end

  // The accumulator is reduced at the handshake so chained ACCs see it at once.
  fxp_reduce #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE)
  ) u_acc_reduce (
    .exact (exact_in),
    .data  (acc_next),
    .ovf   (acc_ovf_unused)
  );

  fxp_reduce #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE)
  ) u_s2_reduce (
    .exact (s1_exact),
    .data  (s2_data),
    .ovf   (s2_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_exact <= exact_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      acc      <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (ready) begin
        s1_valid <= bus.i_valid;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv) begin
        data_q <= s2_data;
        ovf_q  <= s2_ovf;
      end
      if (accept && (bus.i_op == OP_ACC)) begin
        acc <= acc_next;
      end else if (bus.i_acc_clr) begin
        acc <= '0;
      end
      // A set on the same edge as a clear must not be lost.
      if (s2_valid && bus.i_ready && ovf_q) begin
        sticky_q <= 1'b1;
      end else if (bus.i_clr_ovf) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_valid      = s2_valid;
  assign bus.o_data       = data_q;
  assign bus.o_ovf        = ovf_q;
  assign bus.o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// tb/tb_fxp_addsub_pipe.sv - saturating and wrapping instances against a range-arithmetic model
module tb_fxp_addsub_pipe;

  localparam int W = 8;
  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, ACC = 2'd2, NEG = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fxp_addsub_pipe_if #(.DATA_W(W)) bus_sat ();
  fxp_addsub_pipe_if #(.DATA_W(W)) bus_wrap ();

  fxp_addsub_pipe #(.DATA_W(W), .SATURATE(1)) dut_sat (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus_sat)
  );

  fxp_addsub_pipe #(.DATA_W(W), .SATURATE(0)) dut_wrap (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus_wrap)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_cyc = 0;
  bit   chk_en = 0;
  bit   last_acc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   acc_m[2];
  bit   sticky_m[2];
  logic [7:0] last_d[2];
  logic       last_o[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {ovf, data} from the spec's range rules on a plain integer.
  function automatic logic [8:0] ref_reduce(input int e, input bit sat);
    logic [7:0] r;
    bit ov;
    ov = (e > 127) || (e < -128);
    r  = 8'(e);
    if (ov && sat) r = (e > 127) ? 8'h7F : 8'h80;
    return {ov, r};
  endfunction

  task automatic side(input int d, input bit sat,
                      input logic ov, input logic [7:0] od, input logic oo,
                      input logic ordy, input logic ost,
                      input bit v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit aclr, input bit oclr, input bit rdy, input bit rst,
                      output bit accepted);
    exp_t head;
    bit ev, er;
    int n, sa, sb, e;
    logic [8:0] red;
    string s;
    s    = sat ? "sat" : "wrap";
    head = '0;
    n    = (d == 0) ? q0.size() : q1.size();
    if (n > 0) head = (d == 0) ? q0[0] : q1[0];
    ev = (n > 0) && (n_cyc >= head.t + 2);
    er = !(n == 2 && !rdy);
    if (chk_en) begin
      chk({s, ".o_valid"}, 32'(ov), 32'(ev));
      chk({s, ".o_ready"}, 32'(ordy), 32'(er));
      chk({s, ".o_ovf_sticky"}, 32'(ost), 32'(sticky_m[d]));
      if (ev && ov) begin
        chk({s, ".o_data"}, 32'(od), 32'(head.data));
        chk({s, ".o_ovf"}, 32'(oo), 32'(head.ovf));
      end
    end
    accepted = 0;
    if (rst) return;
    if (ev && rdy) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      last_d[d] = head.data;
      last_o[d] = head.ovf;
    end
    if (ev && rdy && head.ovf) sticky_m[d] = 1;
    else if (oclr) sticky_m[d] = 0;
    if (aclr) acc_m[d] = 0;
    accepted = v && er;
    if (accepted) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
        ADD:     e = sa + sb;
        SUB:     e = sa - sb;
        ACC:     e = acc_m[d] + sa;
        default: e = -sa;
      endcase
      red = ref_reduce(e, sat);
      if (op == ACC) acc_m[d] = int'($signed(red[7:0]));
      if (d == 0) q0.push_back('{data: red[7:0], ovf: red[8], t: n_cyc});
      else        q1.push_back('{data: red[7:0], ovf: red[8], t: n_cyc});
    end
  endtask

  task automatic cyc(input bit v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input bit aclr, input bit oclr, input bit rdy, input bit rst);
    bit acc0, acc1;
    @(negedge clk);
    rst_n = !rst;
    bus_sat.i_valid  = v;    bus_wrap.i_valid  = v;
    bus_sat.i_op     = op;   bus_wrap.i_op     = op;
    bus_sat.i_a      = a;    bus_wrap.i_a      = a;
    bus_sat.i_b      = b;    bus_wrap.i_b      = b;
    bus_sat.i_acc_clr = aclr; bus_wrap.i_acc_clr = aclr;
    bus_sat.i_clr_ovf = oclr; bus_wrap.i_clr_ovf = oclr;
    bus_sat.i_ready  = rdy;  bus_wrap.i_ready  = rdy;
    #1;
    side(0, 1, bus_sat.o_valid, bus_sat.o_data, bus_sat.o_ovf, bus_sat.o_ready,
         bus_sat.o_ovf_sticky, v, op, a, b, aclr, oclr, rdy, rst, acc0);
    side(1, 0, bus_wrap.o_valid, bus_wrap.o_data, bus_wrap.o_ovf, bus_wrap.o_ready,
         bus_wrap.o_ovf_sticky, v, op, a, b, aclr, oclr, rdy, rst, acc1);
    last_acc = acc0;
    if (rst) begin
      q0.delete();
      q1.delete();
      acc_m    = '{0, 0};
      sticky_m = '{0, 0};
    end
    n_cyc++;
  endtask

  task automatic idle(input bit oclr, input bit rdy);
    cyc(0, ADD, 8'h00, 8'h00, 0, oclr, rdy, 0);
  endtask

  // rmode: 0 = stalled, 1 = ready, 2 = random ready
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit aclr, input int rmode);
    bit done;
    bit rdy;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = (rmode == 2) ? bit'($urandom_range(0, 1)) : bit'(rmode);
      cyc(1, op, a, b, aclr, 0, rdy, 0);
      done = last_acc;
    end
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (q0.size() + q1.size()) > 0; i++) idle(0, 1);
    chk("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic chk_last(input string tag, input logic [7:0] ds, input logic os,
                          input logic [7:0] dw, input logic ow);
    chk({tag, ".sat.data"}, 32'(last_d[0]), 32'(ds));
    chk({tag, ".sat.ovf"}, 32'(last_o[0]), 32'(os));
    chk({tag, ".wrap.data"}, 32'(last_d[1]), 32'(dw));
    chk({tag, ".wrap.ovf"}, 32'(last_o[1]), 32'(ow));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    acc_m    = '{0, 0};
    sticky_m = '{0, 0};
    cyc(0, ADD, 8'h00, 8'h00, 0, 0, 1, 1);
    cyc(0, ADD, 8'h00, 8'h00, 0, 0, 1, 1);
    chk_en = 1;
    idle(0, 1);
    chk("reset.o_data", 32'(bus_sat.o_data), 32'd0);
    chk("reset.o_ovf", 32'(bus_wrap.o_ovf), 32'd0);

    send(ADD, 8'h70, 8'h20, 0, 1);
    drain();
    chk_last("add_ovf", 8'h7F, 1, 8'h90, 1);
    idle(0, 1);
    chk("add_ovf.sticky", 32'(bus_sat.o_ovf_sticky), 32'd1);

    send(SUB, 8'h80, 8'h01, 0, 1);
    drain();
    chk_last("sub_min", 8'h80, 1, 8'h7F, 1);
    send(NEG, 8'h80, 8'h00, 0, 1);
    drain();
    chk_last("neg_min", 8'h7F, 1, 8'h80, 1);
    send(ADD, 8'h10, 8'h05, 0, 1);
    drain();
    chk_last("add_small", 8'h15, 0, 8'h15, 0);
    send(SUB, 8'h80, 8'h80, 0, 1);
    drain();
    chk_last("sub_min_min", 8'h00, 0, 8'h00, 0);

    cyc(0, ADD, 8'h00, 8'h00, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) send(ACC, 8'h30, 8'h00, 0, 1);
    drain();
    chk_last("acc_chain", 8'h7F, 1, 8'hC0, 0);
    send(ACC, 8'h05, 8'h00, 1, 1);
    drain();
    chk_last("acc_clr", 8'h05, 0, 8'h05, 0);

    for (int i = 0; i < 10; i++) send(ADD, 8'($urandom), 8'($urandom), 0, 2);
    drain();

    idle(1, 1);
    send(ADD, 8'h70, 8'h20, 0, 0);
    idle(0, 0);
    idle(0, 0);
    idle(1, 1);
    idle(0, 1);
    chk("sticky_set_beats_clr", 32'(bus_sat.o_ovf_sticky), 32'd1);
    idle(1, 1);
    idle(0, 1);
    chk("sticky_lone_clr", 32'(bus_sat.o_ovf_sticky), 32'd0);

    for (int i = 0; i < 300; i++) begin
      cyc(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          bit'($urandom_range(0, 1)), 0);
    end
    drain();

    send(ACC, 8'h10, 8'h00, 1, 0);
    send(ADD, 8'h01, 8'h02, 0, 0);
    idle(0, 0);
    chk("full.o_ready", 32'(bus_sat.o_ready), 32'd0);
    cyc(0, ADD, 8'h00, 8'h00, 0, 0, 0, 1);
    idle(0, 1);
    chk("rst_full.acc", 32'(dut_sat.acc), 32'd0);
    chk("rst_full.o_valid", 32'(bus_sat.o_valid), 32'd0);
    chk("rst_full.o_ready", 32'(bus_wrap.o_ready), 32'd1);
    for (int i = 0; i < 3; i++) idle(0, 1);
    send(ACC, 8'h05, 8'h00, 0, 1);
    drain();
    chk_last("acc_after_rst", 8'h05, 0, 8'h05, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fxp_addsub_pipe.md
Name: fxp_addsub_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 8-bit FixedPointAddSub.
- Signed two's-complement fixed-point unit with four ops: add, subtract, accumulate and negate.
- Selectable saturating or wrapping arithmetic, valid/ready handshakes on both sides, and per-result plus sticky overflow flags.
- Sits between a sample source (ADC front-end or test pattern) and downstream filter stages. The board top ties the LEDs to the low bits of o_data.

Parameters:
- DATA_W, 8: operand/result width in bits, signed; legal range 4..32.
- SATURATE, 1: 1 = clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; 0 = wrap (truncate to DATA_W).

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  unit accepts input this cycle.
- i_op  in  2  0=ADD a+b, 1=SUB a-b, 2=ACC acc+a, 3=NEG -a.
- i_a  in  DATA_W  operand a, signed.
- i_b  in  DATA_W  operand b, signed; ignored for ACC/NEG.
- i_acc_clr  in  1  clear accumulator (single-cycle pulse).
- i_clr_ovf  in  1  clear sticky overflow.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_data  out  DATA_W  result, signed.
- o_ovf  out  1  overflow occurred on this result (clamped or wrapped).
- o_ovf_sticky  out  1  any overflow since reset or last clear.

Behaviour:
- Reset: sampled on the rising i_clk edge with i_reset_n=0. Clears s1_valid, s2_valid, acc, o_data, o_ovf and o_ovf_sticky to 0. o_ready=1 in the first cycle after reset. Reset mid-transaction discards all in-flight data without emitting it.
- Pipeline: two register stages, S1 and S2. Latency is exactly 2 cycles from input handshake (i_valid&o_ready) to o_valid, with no backpressure. Throughput is 1 result per cycle.
- Flow control:
  - s2_load = !s2_valid | i_ready.
  - s1_adv = s1_valid & s2_load.
  - o_ready = !s1_valid | s2_load (combinational, no bubble).
  - Output holds o_data/o_ovf stable while o_valid & !i_ready.
- S1 computes a DATA_W+1-bit exact result:
  - ADD: sext(a)+sext(b).
  - SUB: sext(a)-sext(b).
  - NEG: 0-sext(a).
  - ACC: sext(acc)+sext(a).
- S2 reduces to DATA_W:
  - Overflow when the top two bits of the exact result differ.
  - SATURATE=1: clamp to max if positive, min if negative.
  - SATURATE=0: take the low DATA_W bits.
  - o_ovf is registered with o_data.
- Accumulator:
  - Updated at the input handshake of an ACC op, to the reduced (sat/wrap) value of acc+a, so back-to-back ACC ops chain with no hazard.
  - The ACC result emitted equals the new acc value.
- i_acc_clr:
  - Sets acc=0 next cycle.
  - If it coincides with an accepted ACC op, the clear applies first: acc_new = reduce(0+a).
- Sticky overflow:
  - o_ovf_sticky sets when a result with overflow leaves S2 (o_valid & i_ready & o_ovf).
  - i_clr_ovf clears it. A simultaneous set and clear results in set (the event is not lost).
- Edge cases:
  - NEG of min: saturates to max with o_ovf=1, or wraps to min with o_ovf=1.
  - SUB of min-min = 0, no ovf.
- i_op, i_a and i_b are don't-care when i_valid=0. The accumulator never changes without a handshake or i_acc_clr.

Decomposition:
- Package fxp_pkg:
  - Op-code localparams OP_ADD, OP_SUB, OP_ACC, OP_NEG.
  - Function for signed max/min of a given width.
- Sub-module fxp_reduce (combinational): DATA_W+1 exact in -> DATA_W out + ovf, parametrised by DATA_W and SATURATE. It is instantiated twice: in the accumulator update path and in S2.

Test Plan:
- DATA_W=8, SATURATE=1: ADD 0x70+0x20 -> o_data=0x7F, o_ovf=1, o_ovf_sticky=1, o_valid exactly 2 cycles after handshake. Then SUB 0x80-0x01 -> 0x80, ovf=1. NEG 0x80 -> 0x7F, ovf=1.
- SATURATE=0: ADD 0x70+0x20 -> 0x90, ovf=1. NEG 0x80 -> 0x80, ovf=1. ADD 0x10+0x05 -> 0x15, ovf=0.
- Back-to-back ACC with a=0x30 four times, from acc=0 (SAT) -> outputs 0x30, 0x60, 0x7F (ovf), 0x7F (ovf). Then i_acc_clr together with ACC a=0x05 -> output 0x05.
- Backpressure: stream 10 ADDs with i_ready toggling pseudo-randomly -> all 10 results in order, none lost or duplicated. o_data stable while stalled. o_ready drops only when both stages are full and i_ready=0.
- Sticky: overflow result accepted in the same cycle as i_clr_ovf -> o_ovf_sticky=1 afterward. A lone i_clr_ovf -> 0 next cycle.
- Reset asserted with both stages full -> next cycle o_valid=0, acc=0, o_ovf_sticky=0, o_ready=1. No stale result appears after release.
